wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback stage downstream of the functional units (ALU, MEM, MUL, DIV, JUMP).
//  Captures each FU's finish/result/rd into a per-FU one-entry slot.
//  Grants one slot per cycle round-robin and drives the single register-file write port.
//  Exports a pending-rd mask to the control unit for hazard checks.
// PARAMETERS
//  NUM_FU   5   number of FU sources; index 0..4 = ALU, MEM, MUL, DIV, JUMP
//  XLEN     32  result width
//  RADDR_W  5   register address width
// PORTS
//  clk         in   1                clock; all state updates on rising edge
//  rst         in   1                asynchronous, active-low reset
//  fu_valid    in   NUM_FU           per-FU finish pulse, 1 cycle
//  fu_data     in   NUM_FU*XLEN      per-FU result; FU i in [i*XLEN +: XLEN]
//  fu_rd       in   NUM_FU*RADDR_W   per-FU destination reg; FU i in [i*RADDR_W +: RADDR_W]
//  fu_ready    out  NUM_FU           slot i can accept this cycle (combinational)
//  rf_we       out  1                register-file write enable (registered)
//  rf_waddr    out  RADDR_W          write address (registered)
//  rf_wdata    out  XLEN             write data (registered)
//  wb_src      out  3                index of the FU granted for the current rf_* (registered)
//  wb_pending  out  2**RADDR_W       bit r=1 if rd r is held in any slot or in rf_* with rf_we=1
// BEHAVIOUR
//  - Reset (rst=0, async): all slots empty; rf_we=0; rf_waddr=0; rf_wdata=0; wb_src=0; rr_ptr=0.
//    Takes effect mid-operation: in-flight results are discarded.
//  - Slot i state: {full, rd, data}.
//    fu_ready[i] = !full[i] | grant[i], so a slot refills on the same edge it drains.
//  - Accept: fu_valid[i] & fu_ready[i] loads slot i.
//    fu_valid[i] & !fu_ready[i] is a protocol violation; the bench asserts it never occurs.
//  - rd==0: accepted and discarded. The slot stays empty, no write, no grant consumed.
//  - Arbitration: among full slots, first index searching from rr_ptr upward, wrapping at NUM_FU.
//    On a grant, rr_ptr <= (winner+1) mod NUM_FU; with no grant, rr_ptr holds.
//  - Output registers each edge:
//    - grant:    rf_we=1, rf_waddr/rf_wdata=slot, wb_src=winner; slot cleared unless refilled.
//    - no grant: rf_we=0; rf_waddr/rf_wdata/wb_src hold.
//  - Latency (no bypass): fu_valid in cycle C -> slot full in C+1 -> rf_we high in C+2 at best.
//  - Throughput: one write per cycle. Worst-case wait for a full slot is NUM_FU-1 grants.
//  - Simultaneous valids on all 5 FUs: all accepted; written on 5 consecutive cycles in RR order.
//  - Ordering: no ordering between different rd values. The control unit never has two
//    in-flight ops with the same rd, so same-rd ordering is out of scope.
//  - wb_pending is combinational from slot state and rf_* (rf_we qualified). No input paths.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//    - When every slot is empty, the arbiter also considers incoming fu_valid (rd!=0), using
//      the same RR search.
//    - The winner loads rf_* directly on that edge: rf_we high in C+1.
//    - Non-winning incoming valids load their slots as normal.
//  WB_BYPASS_EN undefined: incoming valids always pass through a slot; minimum latency 2.
//  wb_pending semantics are identical in both builds.
// STRUCTURE
//  - Shared package wb_pkg:
//    - FU index constants FU_ALU_IDX=0, FU_MEM_IDX=1, FU_MUL_IDX=2, FU_DIV_IDX=3, FU_JUMP_IDX=4
//    - NUM_FU, XLEN, RADDR_W
//    - typedef wb_slot_t {full, rd, data}
//  - Sub-module wb_rr_picker: request vector + rr_ptr -> one-hot grant + index; purely combinational.
//  - Slot array, rr_ptr and output registers live in wb_arbiter.
// TESTING
//  1. Reset: rst=0 while 3 slots are full.
//     -> rf_we=0, wb_pending=0, fu_ready=5'b11111 immediately, without a clock edge.
//  2. Single ALU result: fu_valid=5'b00001, rd=5, data=32'hDEADBEEF in cycle C.
//     -> rf_we=1, rf_waddr=5, rf_wdata=DEADBEEF, wb_src=0 in C+2 (C+1 with WB_BYPASS_EN).
//  3. All five FUs valid in one cycle, rd=1..5, rr_ptr=0.
//     -> writes rd1, rd2, rd3, rd4, rd5 on consecutive cycles; rr_ptr ends at 0.
//  4. rd==0: MUL valid, rd=0.
//     -> no rf_we ever, fu_ready[2] stays 1, wb_pending unchanged.
//  5. Drain+refill: DIV slot full with rd=7 and granted; DIV valid again same cycle with rd=9.
//     -> fu_ready[3]=1, rd7 written, slot now holds rd9, wb_pending has bits 7 and 9 set.
//  6. Fairness: ALU valid every cycle with rd=1; MEM slot full with rd=2.
//     -> MEM is written within 2 cycles; ALU and MEM grants alternate.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter.
// Sizes, FU index map and the per-FU result slot type.
package wb_pkg;

    localparam int NUM_FU  = 5;
    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int IDX_W   = $clog2(NUM_FU);

    localparam int FU_ALU_IDX  = 0;
    localparam int FU_MEM_IDX  = 1;
    localparam int FU_MUL_IDX  = 2;
    localparam int FU_DIV_IDX  = 3;
    localparam int FU_JUMP_IDX = 4;

    typedef struct packed {
        logic               full;
        logic [RADDR_W-1:0] rd;
        logic [XLEN-1:0]    data;
    } wb_slot_t;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_FU - 1)) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// Purely combinational; returns a one-hot grant and its index.
module wb_rr_picker
    import wb_pkg::*;
(
    input  logic [NUM_FU-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_FU-1:0] gnt,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    localparam logic [IDX_W:0] N = (IDX_W + 1)'(NUM_FU);

    logic [IDX_W:0] pos;

    // Scan from ptr upward and keep the first requester found.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (pos >= N) pos = pos - N;
            if (!any && req[pos[IDX_W-1:0]]) begin
                any                 = 1'b1;
                gnt[pos[IDX_W-1:0]] = 1'b1;
                idx                 = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one-entry slot per FU, round-robin onto one RF write port.
// Optional WB_BYPASS_EN lets an incoming result skip its slot when all slots are empty.
module wb_arbiter
    import wb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_FU-1:0]         fu_valid,
    input  logic [NUM_FU*XLEN-1:0]    fu_data,
    input  logic [NUM_FU*RADDR_W-1:0] fu_rd,
    output logic [NUM_FU-1:0]         fu_ready,
    output logic                      rf_we,
    output logic [RADDR_W-1:0]        rf_waddr,
    output logic [XLEN-1:0]           rf_wdata,
    output logic [IDX_W-1:0]          wb_src,
    output logic [2**RADDR_W-1:0]     wb_pending
);

    wb_slot_t [NUM_FU-1:0] slot_q;
    logic [IDX_W-1:0]      rr_ptr;

    logic [XLEN-1:0]    in_data [NUM_FU];
    logic [RADDR_W-1:0] in_rd   [NUM_FU];
    logic [NUM_FU-1:0]  in_req;
    logic [NUM_FU-1:0]  full;
    logic [NUM_FU-1:0]  req;
    logic [NUM_FU-1:0]  gnt;
    logic [NUM_FU-1:0]  slot_gnt;
    logic [NUM_FU-1:0]  byp_gnt;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic               win_byp;
    logic [RADDR_W-1:0] win_rd;
    logic [XLEN-1:0]    win_data;

    // Unpack flat FU buses; rd==0 results never count as requests.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            in_data[i] = fu_data[i*XLEN +: XLEN];
            in_rd[i]   = fu_rd[i*RADDR_W +: RADDR_W];
            in_req[i]  = fu_valid[i] && (in_rd[i] != '0);
            full[i]    = slot_q[i].full;
        end
    end

`ifdef WB_BYPASS_EN
    logic bypass;
    assign bypass   = ~|full;
    assign req      = bypass ? in_req : full;
    assign slot_gnt = bypass ? '0 : gnt;
    assign byp_gnt  = bypass ? gnt : '0;
`else
    assign req      = full;
    assign slot_gnt = gnt;
    assign byp_gnt  = '0;
`endif

    wb_rr_picker u_picker (
        .req (req),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win_idx),
        .any (win_any)
    );

    assign fu_ready = ~full | slot_gnt;
    assign win_byp  = |byp_gnt;
    assign win_rd   = win_byp ? in_rd[win_idx]   : slot_q[win_idx].rd;
    assign win_data = win_byp ? in_data[win_idx] : slot_q[win_idx].data;

    // Pending mask: every rd held in a slot or on a live RF write.
    always_comb begin
        wb_pending = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (slot_q[i].full) wb_pending[slot_q[i].rd] = 1'b1;
        end
        if (rf_we) wb_pending[rf_waddr] = 1'b1;
    end

    // Slot fill/drain, round-robin pointer and registered RF write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q   <= '0;
            rr_ptr   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wb_src   <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (in_req[i] && fu_ready[i] && !byp_gnt[i]) begin
                    slot_q[i].full <= 1'b1;
                    slot_q[i].rd   <= in_rd[i];
                    slot_q[i].data <= in_data[i];
                end else if (slot_gnt[i]) begin
                    slot_q[i].full <= 1'b0;
                end
            end
            rf_we <= win_any;
            if (win_any) begin
                rf_waddr <= win_rd;
                rf_wdata <= win_data;
                wb_src   <= win_idx;
                rr_ptr   <= next_idx(win_idx);
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter.
// Expected RF writes are queued at stimulus time and popped as rf_we fires.
module tb_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   fu_valid;
    logic [159:0] fu_data;
    logic [24:0]  fu_rd;
    logic [4:0]   fu_ready;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic [2:0]   wb_src;
    logic [31:0]  wb_pending;

`ifdef WB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  src;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;

    wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .fu_valid   (fu_valid),
        .fu_data    (fu_data),
        .fu_rd      (fu_rd),
        .fu_ready   (fu_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .wb_src     (wb_src),
        .wb_pending (wb_pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     tag, act, exp, cyc);
        end
    endtask

    task automatic set_fu(input int i, input logic [4:0] rd,
                          input logic [31:0] d);
        fu_valid[i]         = 1'b1;
        fu_rd[i*5 +: 5]     = rd;
        fu_data[i*32 +: 32] = d;
    endtask

    task automatic push(input int c, input logic [4:0] rd,
                        input logic [31:0] d, input logic [2:0] s);
        exp_t e;
        e.cyc  = c;
        e.rd   = rd;
        e.data = d;
        e.src  = s;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        fu_valid = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        fu_valid = '0;
        @(negedge clk);
        sb.delete();
        rst = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    // Protocol check and scoreboard compare, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            check("proto", fu_valid & ~fu_ready, 0);
            if (rf_we) begin
                if (sb.size() == 0) begin
                    check("unexp_we", rf_we, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("waddr", rf_waddr, e.rd);
                    check("wdata", rf_wdata, e.data);
                    check("wb_src", wb_src, e.src);
                    if (e.cyc >= 0) check("latency", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int          c;
        int          n;
        logic [31:0] p;
        rst      = 1'b0;
        fu_valid = '0;
        fu_data  = '0;
        fu_rd    = '0;

        repeat (2) @(negedge clk);
        check("rst_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_src", wb_src, 0);
        check("rst_pend", wb_pending, 0);
        check("rst_ready", fu_ready, 5'h1f);
        rst = 1'b1;

        // Async reset while three slots hold results
        next_cycle();
        set_fu(2, 10, 32'h1010);
        set_fu(3, 11, 32'h1111);
        set_fu(4, 12, 32'h1212);
        next_cycle();
        check("pre_rst_pend", wb_pending, 32'h1c00);
        #1 rst = 1'b0;
        #1;
        check("arst_we", rf_we, 0);
        check("arst_pend", wb_pending, 0);
        check("arst_ready", fu_ready, 5'h1f);
        @(negedge clk);
        sb.delete();
        rst = 1'b1;

        // Single ALU result
        do_reset();
        next_cycle();
        c = cyc;
        set_fu(0, 5, 32'hdeadbeef);
        push(c + LAT, 5, 32'hdeadbeef, 0);
        next_cycle();
        drain();

        // All five FUs in one cycle
        do_reset();
        next_cycle();
        c = cyc;
        for (int i = 0; i < 5; i++) begin
            set_fu(i, 5'(i + 1), 32'hc0 + i);
            push(c + LAT + i, 5'(i + 1), 32'hc0 + i, 3'(i));
        end
        next_cycle();
        drain();
        repeat (2) @(posedge clk);
        check("rr_ptr_end", dut.rr_ptr, 0);

        // rd==0 is swallowed
        next_cycle();
        p = wb_pending;
        set_fu(2, 0, 32'h1234);
        check("rd0_ready", fu_ready[2], 1);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            check("rd0_ready_hold", fu_ready[2], 1);
            check("rd0_pend", wb_pending, p);
        end

        // DIV drains and refills on the same edge
        do_reset();
        next_cycle();
        c = cyc;
`ifdef WB_BYPASS_EN
        set_fu(0, 6, 32'h66);
        push(c + 1, 6, 32'h66, 0);
`endif
        set_fu(3, 7, 32'h77);
        push(c + 2, 7, 32'h77, 3);
        next_cycle();
        check("refill_ready", fu_ready[3], 1);
        set_fu(3, 9, 32'h99);
        push(c + 3, 9, 32'h99, 3);
        next_cycle();
        check("refill_pend", wb_pending, 32'h280);
        drain();

        // Fairness: ALU streaming, one MEM result waiting
        do_reset();
        next_cycle();
        c = cyc;
        set_fu(0, 1, 32'ha000);
        set_fu(1, 2, 32'hb000);
        push(-1, 1, 32'ha000, 0);
        push(c + LAT + 1, 2, 32'hb000, 1);
        n = 1;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            if (fu_ready[0] && n < 6) begin
                set_fu(0, 1, 32'ha000 + n);
                push(-1, 1, 32'ha000 + n, 0);
                n++;
            end
        end
        fu_valid = '0;
        drain();
        check("fair_count", n, 6);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
